// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the dual-channel DAC SPI scheduler.
package dac_spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHi,
        StLo,
        StGap
    } state_e;

    localparam logic [3:0]  CH_A       = 4'h0;
    localparam logic [3:0]  CH_B       = 4'h1;
    localparam int unsigned FRAME_BITS = 24;

    // DAC expects offset binary; flipping the sign bit maps two's complement onto it.
    function automatic logic [15:0] to_offset_binary(input logic [15:0] sample);
        return {~sample[15], sample[14:0]};
    endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// Frame shift register, MSB first, with a down-counting bit index.
module dac_spi_shifter
    import dac_spi_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET_,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  shift,
    output logic                  sdi,
    output logic                  last_bit
);

    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [4:0]            cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = frame;
            cnt_d = 5'(FRAME_BITS - 1);
        end else if (shift) begin
            // Zero fill leaves SDI low once the final bit has gone out.
            sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
            if (cnt_q != 5'd0) begin
                cnt_d = cnt_q - 5'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sdi      = sr_q[FRAME_BITS-1];
    assign last_bit = (cnt_q == 5'd0);

endmodule

// File: rtl/dac_spi_scheduler.sv
// SPI master sharing one dual-channel DAC between two round-robin sample requesters.
module dac_spi_scheduler
    import dac_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_IDLE    = 2,
    parameter logic [3:0]  CTRL_UPPER = 4'h0
) (
    input  logic        CLK,
    input  logic        RESET_,
    input  logic        REQ_A,
    input  logic [15:0] DATA_A,
    output logic        ACK_A,
    input  logic        REQ_B,
    input  logic [15:0] DATA_B,
    output logic        ACK_B,
    output logic        BUSY,
    output logic        SCK,
    output logic        SDI,
    output logic        CS_
);

    localparam int unsigned DIV_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int unsigned DIV_W   = $clog2(DIV_MAX) + 1;
    localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_END = DIV_W'(CS_IDLE - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             last_grant_q, last_grant_d;  // 1: B was granted most recently
    logic             last_q, last_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             busy_q, busy_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;

    logic                  grant_a, grant_b;
    logic [15:0]           data_sel;
    logic [FRAME_BITS-1:0] frame;
    logic                  load, shift, last_bit;

    assign grant_a  = REQ_A & (~REQ_B | last_grant_q);
    assign grant_b  = REQ_B & ~grant_a;
    assign data_sel = grant_a ? DATA_A : DATA_B;
    assign frame    = {CTRL_UPPER, grant_a ? CH_A : CH_B, to_offset_binary(data_sel)};

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        last_grant_d = last_grant_q;
        last_d       = last_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        busy_d       = busy_q;
        sck_d        = sck_q;
        cs_n_d       = cs_n_q;
        load         = 1'b0;
        shift        = 1'b0;

        case (state_q)
            StIdle: begin
                if (REQ_A || REQ_B) begin
                    load         = 1'b1;
                    ack_a_d      = grant_a;
                    ack_b_d      = grant_b;
                    last_grant_d = grant_b;
                    last_d       = 1'b0;
                    busy_d       = 1'b1;
                    cs_n_d       = 1'b0;
                    sck_d        = 1'b0;
                    div_d        = '0;
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                if (div_q == DIV_END) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    state_d = StHi;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StHi: begin
                if (div_q == DIV_END) begin
                    div_d   = '0;
                    sck_d   = 1'b0;
                    shift   = 1'b1;
                    last_d  = last_bit;
                    state_d = StLo;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StLo: begin
                if (div_q == DIV_END) begin
                    div_d = '0;
                    if (last_q) begin
                        cs_n_d  = 1'b1;
                        state_d = StGap;
                    end else begin
                        sck_d   = 1'b1;
                        state_d = StHi;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StGap: begin
                if (div_q == GAP_END) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                sck_d   = 1'b0;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            state_q      <= StIdle;
            div_q        <= '0;
            last_grant_q <= 1'b1;
            last_q       <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            busy_q       <= 1'b0;
            sck_q        <= 1'b0;
            cs_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            last_grant_q <= last_grant_d;
            last_q       <= last_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            busy_q       <= busy_d;
            sck_q        <= sck_d;
            cs_n_q       <= cs_n_d;
        end
    end

    dac_spi_shifter u_shifter (
        .CLK      (CLK),
        .RESET_   (RESET_),
        .load     (load),
        .frame    (frame),
        .shift    (shift),
        .sdi      (SDI),
        .last_bit (last_bit)
    );

    assign ACK_A = ack_a_q;
    assign ACK_B = ack_b_q;
    assign BUSY  = busy_q;
    assign SCK   = sck_q;
    assign CS_   = cs_n_q;

endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Directed bench for dac_spi_scheduler with a DAC-side SPI frame monitor.
module tb_dac_spi_scheduler;

    logic        CLK = 1'b0;
    logic        RESET_ = 1'b0;
    logic        REQ_A = 1'b0, REQ_B = 1'b0;
    logic [15:0] DATA_A = '0, DATA_B = '0;
    logic        ACK_A, ACK_B, BUSY, SCK, SDI, CS_;

    int n_checks = 0;
    int n_err = 0;

    dac_spi_scheduler #(
        .CLK_DIV    (2),
        .CS_IDLE    (2),
        .CTRL_UPPER (4'h0)
    ) dut (
        .CLK    (CLK),
        .RESET_ (RESET_),
        .REQ_A  (REQ_A),
        .DATA_A (DATA_A),
        .ACK_A  (ACK_A),
        .REQ_B  (REQ_B),
        .DATA_B (DATA_B),
        .ACK_B  (ACK_B),
        .BUSY   (BUSY),
        .SCK    (SCK),
        .SDI    (SDI),
        .CS_    (CS_)
    );

    always #5 CLK = ~CLK;

    // DAC model: samples SDI on SCK rise, logs a write only for a complete 24-bit frame.
    logic [23:0] m_sr = '0;
    int          m_bits = 0, m_low = 0, m_high = 0;
    int          m_writes = 0, m_aborts = 0, m_wide = 0;
    bit          cs_prev_low = 0, sck_prev = 0, gap_valid = 0;
    bit          acka_prev = 0, ackb_prev = 0;
    logic [23:0] m_frames[$];
    int          m_lows[$];
    int          m_gaps[$];

    always @(negedge CLK) begin
        if (CS_ === 1'b0) begin
            if (!cs_prev_low) begin
                m_bits = 0;
                m_sr   = '0;
                m_low  = 0;
                if (gap_valid) m_gaps.push_back(m_high);
            end
            m_low++;
            if (SCK === 1'b1 && !sck_prev) begin
                m_sr = {m_sr[22:0], SDI};
                m_bits++;
            end
        end else begin
            if (cs_prev_low) begin
                if (m_bits == 24) begin
                    m_frames.push_back(m_sr);
                    m_lows.push_back(m_low);
                    m_writes++;
                end else begin
                    m_aborts++;
                end
                m_high    = 0;
                gap_valid = 1;
            end
            m_high++;
        end
        if ((ACK_A === 1'b1 && acka_prev) || (ACK_B === 1'b1 && ackb_prev)) m_wide++;
        acka_prev   = (ACK_A === 1'b1);
        ackb_prev   = (ACK_B === 1'b1);
        cs_prev_low = (CS_ === 1'b0);
        sck_prev    = (SCK === 1'b1);
    end

    typedef struct {
        logic        req_a;
        logic        req_b;
        logic [15:0] da;
        logic [15:0] db;
        logic        exp_a;
        logic        exp_b;
        logic [23:0] exp_frame;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output logic got_a, output logic got_b, output bit ok);
        ok = 0;
        got_a = 0;
        got_b = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (ACK_A === 1'b1 || ACK_B === 1'b1) begin
                got_a = ACK_A;
                got_b = ACK_B;
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (BUSY === 1'b0) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (m_frames.size() >= n) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic        ga, gb;
        bit          ok, quiet;
        int          order[$];
        int          gaps_before, writes_before;
        logic [23:0] fr;

        vecs[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 24'h009234};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h8000, 1'b0, 1'b1, 24'h010000};
        vecs[2] = '{1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 24'h00FFFF};
        vecs[3] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 24'h017FFF};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 24'h007FFF};
        vecs[5] = '{1'b1, 1'b1, 16'h8001, 16'h00AA, 1'b0, 1'b1, 24'h0180AA};

        // Reset state and quiet idle.
        repeat (3) tick();
        check("rst_cs", CS_, 1);
        check("rst_sck", SCK, 0);
        check("rst_sdi", SDI, 0);
        check("rst_ack", {ACK_A, ACK_B}, 0);
        check("rst_busy", BUSY, 0);
        RESET_ = 1'b1;
        quiet = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if ({CS_, SCK, SDI, BUSY, ACK_A, ACK_B} !== 6'b100000) quiet = 0;
        end
        check("idle_quiet", quiet, 1);
        check("idle_no_write", m_writes, 0);

        // Single transactions and round-robin ties from idle.
        for (int v = 0; v < 6; v++) begin
            wait_idle(ok);
            check("vec_idle", ok, 1);
            REQ_A = vecs[v].req_a;
            REQ_B = vecs[v].req_b;
            DATA_A = vecs[v].da;
            DATA_B = vecs[v].db;
            wait_ack(ga, gb, ok);
            REQ_A = 1'b0;
            REQ_B = 1'b0;
            check("vec_ack_seen", ok, 1);
            check("vec_ack_a", ga, vecs[v].exp_a);
            check("vec_ack_b", gb, vecs[v].exp_b);
            tick();
            check("vec_ack_pulse", {ACK_A, ACK_B}, 0);
            check("vec_cs_low", CS_, 0);
            check("vec_busy", BUSY, 1);
            wait_frames(1, ok);
            check("vec_frame_seen", ok, 1);
            if (ok) begin
                fr = m_frames.pop_front();
                check("vec_frame", fr, vecs[v].exp_frame);
                check("vec_cs_low_len", m_lows.pop_front(), 98);
            end
        end

        // Both held after reset: A,B,A,B with CS_IDLE+1 high cycles between frames.
        wait_idle(ok);
        RESET_ = 1'b0;
        tick();
        RESET_ = 1'b1;
        gaps_before = m_gaps.size();
        DATA_A = 16'h1111;
        DATA_B = 16'h2222;
        REQ_A = 1'b1;
        REQ_B = 1'b1;
        for (int i = 0; i < 1000 && order.size() < 4; i++) begin
            tick();
            if (ACK_A === 1'b1) order.push_back(0);
            if (ACK_B === 1'b1) order.push_back(1);
        end
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        check("rr_ack_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) check("rr_order", order[i], i % 2);
        wait_frames(4, ok);
        check("rr_frames_seen", ok, 1);
        for (int i = 0; i < 4 && m_frames.size() > 0; i++) begin
            fr = m_frames.pop_front();
            check("rr_frame", fr, (i % 2 == 0) ? 24'h009111 : 24'h01A222);
            check("rr_cs_low_len", m_lows.pop_front(), 98);
        end
        for (int i = 1; i < 4; i++) begin
            if (gaps_before + i < m_gaps.size()) check("rr_gap", m_gaps[gaps_before + i], 3);
            else check("rr_gap_logged", 0, 1);
        end

        // Request raised during GAP waits for IDLE.
        wait_idle(ok);
        REQ_A = 1'b1;
        DATA_A = 16'h00FF;
        wait_ack(ga, gb, ok);
        REQ_A = 1'b0;
        check("gap_first_ack", ga, 1);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (CS_ === 1'b1) break;
        end
        check("gap_cs_high", CS_, 1);
        REQ_A = 1'b1;
        DATA_A = 16'h0F0F;
        tick();
        check("gap_no_ack1", ACK_A, 0);
        check("gap_busy1", BUSY, 1);
        tick();
        check("gap_idle_busy", BUSY, 0);
        check("gap_no_ack2", ACK_A, 0);
        tick();
        check("gap_ack", ACK_A, 1);
        check("gap_cs_low", CS_, 0);
        REQ_A = 1'b0;
        wait_frames(2, ok);
        check("gap_frames_seen", ok, 1);
        if (ok) begin
            check("gap_frame1", m_frames.pop_front(), 24'h0080FF);
            check("gap_frame2", m_frames.pop_front(), 24'h008F0F);
            void'(m_lows.pop_front());
            void'(m_lows.pop_front());
        end

        // Reset after the 10th SCK rise discards the frame; held request re-granted.
        wait_idle(ok);
        REQ_A = 1'b1;
        DATA_A = 16'h4321;
        wait_ack(ga, gb, ok);
        check("mid_ack", ga, 1);
        for (int i = 0; i < 300; i++) begin
            if (m_bits == 10 && CS_ === 1'b0) break;
            tick();
        end
        check("mid_bits10", m_bits, 10);
        writes_before = m_writes;
        RESET_ = 1'b0;
        #1;
        check("mid_cs", CS_, 1);
        check("mid_sck", SCK, 0);
        check("mid_sdi", SDI, 0);
        check("mid_busy", BUSY, 0);
        repeat (2) tick();
        RESET_ = 1'b1;
        wait_ack(ga, gb, ok);
        REQ_A = 1'b0;
        check("mid_reack", ga, 1);
        wait_frames(1, ok);
        check("mid_frame_seen", ok, 1);
        if (ok) begin
            check("mid_frame", m_frames.pop_front(), 24'h00C321);
            check("mid_cs_low_len", m_lows.pop_front(), 98);
        end
        wait_idle(ok);
        repeat (50) tick();
        check("mid_one_write", m_writes - writes_before, 1);
        check("mid_abort", m_aborts, 1);
        check("ack_width", m_wide, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
